// File: rtl/histogram_ctrl.sv
// histogram_ctrl: sequencer for the histogram kernel.
// Clears the bin RAM, streams pixels from the image RAM and performs a
// two-stage read-modify-write increment per pixel, then pulses done.
// Build option: HISTOGRAM_CTRL_FWD_EN enables write->read forwarding so
// pixels issue every cycle; without it pixels issue every other cycle.
module histogram_ctrl #(
    parameter int IMG_AW = 12,
    parameter int BIN_AW = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IMG_AW:0]   num_pixels,
    output logic              busy,
    output logic              done,
    output logic [IMG_AW-1:0] img_raddr,
    input  logic [BIN_AW-1:0] img_rdata,
    output logic [BIN_AW-1:0] bin_raddr,
    input  logic [CNT_W-1:0]  bin_rdata,
    output logic [BIN_AW-1:0] bin_waddr,
    output logic [CNT_W-1:0]  bin_wdata,
    output logic              bin_wen
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [IMG_AW:0] MAX_PIX = {1'b1, {IMG_AW{1'b0}}};

    state_t              state_q, state_d;
    logic [IMG_AW:0]     n_q;       // clamped pixel count
    logic [IMG_AW:0]     iss_q;     // next pixel index to issue
    logic [BIN_AW-1:0]   clr_q;     // clear address
    logic                drain_q;   // second drain cycle marker
    logic [2:1]          vld_pipe;  // [1]: stage-1 valid, [2]: stage-2 valid
    logic [BIN_AW-1:0]   idx_q;     // bin index carried into stage 2
    logic                issue;
    logic                last_issue;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    wdata_s2;

`ifdef HISTOGRAM_CTRL_FWD_EN
    logic                fwd_wen_q;
    logic [BIN_AW-1:0]   fwd_waddr_q;
    logic [CNT_W-1:0]    fwd_wdata_q;
`else
    logic                phase_q;   // pixels issue on odd RUN cycles
`endif

    // Pixel issue qualifier: every RUN cycle, or every second one without forwarding
    always_comb begin
`ifdef HISTOGRAM_CTRL_FWD_EN
        issue = (state_q == S_RUN);
`else
        issue = (state_q == S_RUN) && phase_q;
`endif
        last_issue = issue && (iss_q == n_q - 1'b1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: if (clr_q == {BIN_AW{1'b1}})
                         state_d = (n_q == '0) ? S_DRAIN : S_RUN;
            S_RUN:   if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Run counters and count latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q     <= '0;
            iss_q   <= '0;
            clr_q   <= '0;
            drain_q <= 1'b0;
`ifndef HISTOGRAM_CTRL_FWD_EN
            phase_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    n_q     <= (num_pixels > MAX_PIX) ? MAX_PIX : num_pixels;
                    iss_q   <= '0;
                    clr_q   <= '0;
                    drain_q <= 1'b0;
`ifndef HISTOGRAM_CTRL_FWD_EN
                    phase_q <= 1'b0;
`endif
                end
                S_CLEAR: clr_q <= clr_q + 1'b1;
                S_RUN: begin
                    if (issue) iss_q <= iss_q + 1'b1;
`ifndef HISTOGRAM_CTRL_FWD_EN
                    phase_q <= ~phase_q;
`endif
                end
                S_DRAIN: drain_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Pipeline valids and stage-1 -> stage-2 bin index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            idx_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], issue};
            if (vld_pipe[1]) idx_q <= img_rdata;
        end
    end

`ifdef HISTOGRAM_CTRL_FWD_EN
    // Remember the previous stage-2 write; the RAM returns stale data for it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_wen_q   <= 1'b0;
            fwd_waddr_q <= '0;
            fwd_wdata_q <= '0;
        end else begin
            fwd_wen_q   <= vld_pipe[2];
            fwd_waddr_q <= idx_q;
            fwd_wdata_q <= wdata_s2;
        end
    end
`endif

    // Stage-2 increment with optional forwarding of the previous write
    always_comb begin
        count = bin_rdata;
`ifdef HISTOGRAM_CTRL_FWD_EN
        if (fwd_wen_q && (fwd_waddr_q == idx_q)) count = fwd_wdata_q;
`endif
        wdata_s2 = count + 1'b1;
    end

    // Output drive; everything is zero when not actively used
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        img_raddr = issue ? iss_q[IMG_AW-1:0] : '0;
        bin_raddr = vld_pipe[1] ? img_rdata : '0;
        bin_wen   = 1'b0;
        bin_waddr = '0;
        bin_wdata = '0;
        if (state_q == S_CLEAR) begin
            bin_wen   = 1'b1;
            bin_waddr = clr_q;
        end else if (vld_pipe[2]) begin
            bin_wen   = 1'b1;
            bin_waddr = idx_q;
            bin_wdata = wdata_s2;
        end
    end

endmodule

// File: tb/tb_histogram_ctrl.sv
// Directed bench for histogram_ctrl with behavioural image and bin RAMs.
module tb_histogram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] num_pixels;
    logic        busy, done;
    logic [11:0] img_raddr;
    logic [7:0]  img_rdata;
    logic [7:0]  bin_raddr;
    logic [31:0] bin_rdata;
    logic [7:0]  bin_waddr;
    logic [31:0] bin_wdata;
    logic        bin_wen;

    logic [7:0]  img_mem [4096];
    logic [31:0] bin_mem [256];
    logic [31:0] snap    [256];
    int unsigned exp_bins[256];
    logic        prefill = 1'b0;
    int          done_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    histogram_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels),
        .busy(busy), .done(done), .img_raddr(img_raddr), .img_rdata(img_rdata),
        .bin_raddr(bin_raddr), .bin_rdata(bin_rdata), .bin_waddr(bin_waddr),
        .bin_wdata(bin_wdata), .bin_wen(bin_wen)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models: read data one cycle later, old data on collision
    always @(posedge clk) begin
        img_rdata <= img_mem[img_raddr];
        bin_rdata <= bin_mem[bin_raddr];
        if (prefill) begin
            for (int k = 0; k < 256; k++) bin_mem[k] <= 32'hFFFF_FFFF;
        end else if (bin_wen) begin
            bin_mem[bin_waddr] <= bin_wdata;
        end
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int n);
`ifdef HISTOGRAM_CTRL_FWD_EN
        return 256 + n + 2;
`else
        return 256 + 2 * n + 2;
`endif
    endfunction

    function automatic void model(input int n);
        for (int k = 0; k < 256; k++) exp_bins[k] = 0;
        for (int i = 0; i < n; i++) exp_bins[img_mem[i]]++;
    endfunction

    task automatic cmp_bins(input string tag);
        int bad = 0;
        for (int k = 0; k < 256; k++) if (bin_mem[k] !== exp_bins[k]) bad++;
        chk(tag, bad, 0);
    endtask

    // Start a run, optionally pulse start again at cycle rs_at, check done latency
    task automatic run(input int n, input int rs_at, input int rs_n, input string tag);
        int cyc;
        @(negedge clk); start = 1'b1; num_pixels = n[12:0];
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == rs_at) begin
                start = 1'b1; num_pixels = rs_n[12:0];
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, cyc, lat_of(n));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; num_pixels = '0;
        for (int i = 0; i < 4096; i++) img_mem[i] = 8'd0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wen", bin_wen, 0);
        chk("rst_iaddr", img_raddr, 0);
        chk("rst_waddr", bin_waddr, 0);
        chk("rst_wdata", bin_wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Ramp image, N=100
        for (int i = 0; i < 4096; i++) img_mem[i] = 8'(i % 256);
        model(100);
        run(100, -1, 0, "ramp");
        cmp_bins("ramp_bins");
        chk("ramp_b0", bin_mem[0], 1);
        chk("ramp_b99", bin_mem[99], 1);
        chk("ramp_b100", bin_mem[100], 0);

        // All pixels identical: back-to-back same bin
        for (int i = 0; i < 8; i++) img_mem[i] = 8'h2A;
        model(8);
        run(8, -1, 0, "same");
        chk("same_b42", bin_mem[42], 8);
        cmp_bins("same_bins");

        // Alternating 3,7: distance-2 reuse
        for (int i = 0; i < 10; i++) img_mem[i] = (i % 2 == 0) ? 8'd3 : 8'd7;
        model(10);
        run(10, -1, 0, "alt");
        chk("alt_b3", bin_mem[3], 5);
        chk("alt_b7", bin_mem[7], 5);
        cmp_bins("alt_bins");

        // Prefilled bins, N=0: only the clear pass writes
        @(negedge clk); prefill = 1'b1;
        @(negedge clk); prefill = 1'b0;
        chk("pre_filled", bin_mem[17], 32'hFFFF_FFFF);
        model(0);
        run(0, -1, 0, "zero");
        cmp_bins("zero_bins");

        // Restart attempt during RUN is ignored
        for (int i = 0; i < 64; i++) img_mem[i] = 8'(i % 5);
        model(30);
        d0 = done_cnt;
        run(30, 262, 50, "restart");
        repeat (5) @(negedge clk);
        chk("restart_done_pulses", done_cnt - d0, 1);
        chk("restart_b0", bin_mem[0], 6);
        cmp_bins("restart_bins");

        // Asynchronous reset mid-RUN
        for (int i = 0; i < 20; i++) img_mem[i] = 8'(i % 7);
        @(negedge clk); start = 1'b1; num_pixels = 13'd20;
        @(negedge clk); start = 1'b0;
        repeat (260) @(negedge clk);
        chk("ar_busy_before", busy, 1);
        #2 rst = 1'b1;
        for (int k = 0; k < 256; k++) snap[k] = bin_mem[k];
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_wen", bin_wen, 0);
        chk("ar_done", done, 0);
        chk("ar_iaddr", img_raddr, 0);
        repeat (3) @(negedge clk);
        begin
            int diff = 0;
            for (int k = 0; k < 256; k++) if (bin_mem[k] !== snap[k]) diff++;
            chk("ar_no_writes", diff, 0);
        end
        rst = 1'b0;
        img_mem[0] = 8'd9; img_mem[1] = 8'd9; img_mem[2] = 8'd200; img_mem[3] = 8'd9;
        model(4);
        run(4, -1, 0, "post_rst");
        chk("post_rst_b9", bin_mem[9], 3);
        chk("post_rst_b200", bin_mem[200], 1);
        cmp_bins("post_rst_bins");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
